// File: rtl/conv3x3_stream_v2.sv
// ============================================================================
// Module   : conv3x3_stream_v2
// Purpose  : 3x3 "valid"-mode streaming convolution, AXI4-Stream in/out,
//            programmable kernel committed at frame boundaries.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module conv3x3_stream_v2 #(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int PIXEL_NB           = 8,
    parameter int KERNEL_NB          = 8,
    parameter int IMG_WIDTH          = 64,
    parameter int IMG_HEIGHT         = 64,
    parameter int SHIFT              = 0
) (
    input  logic                            s00_axis_aclk,
    input  logic                            s00_axis_aresetn,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                            s00_axis_tvalid,
    output logic                            s00_axis_tready,
    input  logic                            s00_axis_tlast,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                            m00_axis_tvalid,
    input  logic                            m00_axis_tready,
    output logic                            m00_axis_tlast,
    input  logic                            cfg_we,
    input  logic [3:0]                      cfg_addr,
    input  logic [KERNEL_NB-1:0]            cfg_data,
    output logic                            frame_err
);

    localparam int CW    = $clog2(IMG_WIDTH);
    localparam int RW    = $clog2(IMG_HEIGHT);
    localparam int ACC_W = PIXEL_NB + KERNEL_NB + 4;
    localparam logic [CW-1:0]              COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0]              ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic signed [ACC_W-1:0]    PIX_MAX  = ACC_W'((1 << PIXEL_NB) - 1);
    localparam logic signed [KERNEL_NB-1:0] K_ONE   = KERNEL_NB'(1);

    logic                 en, accept, at_end, interior, early_last;
    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic [PIXEL_NB-1:0]  pix;
    logic                 s1_valid, s1_last, commit;
    logic [PIXEL_NB-1:0]  lb0 [IMG_WIDTH];
    logic [PIXEL_NB-1:0]  lb1 [IMG_WIDTH];
    logic [PIXEL_NB-1:0]  win [3][3];
    logic signed [KERNEL_NB-1:0] shadow [3][3];
    logic signed [KERNEL_NB-1:0] active [3][3];
    logic signed [ACC_W-1:0] acc, shifted, pw, kw;
    logic [PIXEL_NB-1:0]  sat;
    logic                 unused_inputs;

    assign en              = ~m00_axis_tvalid | m00_axis_tready;
    assign s00_axis_tready = en;
    assign accept          = s00_axis_tvalid & en;
    assign pix             = s00_axis_tdata[PIXEL_NB-1:0];
    assign at_end          = (row == ROW_LAST) && (col == COL_LAST);
    assign interior        = (row >= RW'(2)) && (col >= CW'(2));
    assign early_last      = s00_axis_tlast & ~at_end;
    assign m00_axis_tstrb  = '1;
    assign unused_inputs   = &{1'b0, s00_axis_tstrb,
                               s00_axis_tdata[C_AXIS_TDATA_WIDTH-1:PIXEL_NB]};

    // A stage-1 beat that moves on this edge still sees the old bank, so the
    // swap may coincide with it; only a frozen interior beat blocks it.
    assign commit = (row == '0) && (col == '0) && (!s1_valid || en);

    // Stage 1 storage: line buffers and window are pure datapath, not reset.
    always_ff @(posedge s00_axis_aclk) begin
        if (accept) begin
            lb0[col] <= lb1[col];
            lb1[col] <= pix;
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb0[col];
            win[1][2] <= lb1[col];
            win[2][2] <= pix;
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            row       <= '0;
            col       <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            frame_err <= 1'b0;
        end else if (accept) begin
            if (early_last) begin
                row       <= '0;
                col       <= '0;
                s1_valid  <= 1'b0;
                s1_last   <= 1'b0;
                frame_err <= 1'b1;
            end else begin
                s1_valid <= interior;
                s1_last  <= at_end;
                if (at_end) begin
                    row <= '0;
                    col <= '0;
                    if (!s00_axis_tlast)
                        frame_err <= 1'b1;
                end else if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end else if (en) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    shadow[r][c] <= (r == 1 && c == 1) ? K_ONE : '0;
                    active[r][c] <= (r == 1 && c == 1) ? K_ONE : '0;
                end
            end
        end else begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    if (cfg_we && cfg_addr == 4'(r * 3 + c))
                        shadow[r][c] <= cfg_data;
                    if (commit)
                        active[r][c] <= shadow[r][c];
                end
            end
        end
    end

    always_comb begin
        acc = '0;
        pw  = '0;
        kw  = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                pw  = ACC_W'($signed({1'b0, win[r][c]}));
                kw  = ACC_W'(active[r][c]);
                acc = acc + pw * kw;
            end
        end
        shifted = acc >>> SHIFT;
        if (shifted[ACC_W-1])
            sat = '0;
        else if (shifted > PIX_MAX)
            sat = '1;
        else
            sat = shifted[PIXEL_NB-1:0];
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tdata  <= '0;
        end else if (en) begin
            m00_axis_tvalid <= s1_valid;
            m00_axis_tlast  <= s1_valid & s1_last;
            if (s1_valid)
                m00_axis_tdata <= {{(C_AXIS_TDATA_WIDTH-PIXEL_NB){1'b0}}, sat};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conv3x3_stream_v2.sv
// ============================================================================
// Module   : tb_conv3x3_stream_v2
// Purpose  : Directed self-checking bench for conv3x3_stream_v2 on 5x5 frames.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_conv3x3_stream_v2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tstrb = '1;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [7:0]  cfg_data = '0;
    logic        frame_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit stall_mode = 1'b0;
    bit ready_req = 1'b1;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;
    beat_t q[$];

    int exp_id[9]  = '{11, 12, 13, 21, 22, 23, 31, 32, 33};
    int exp_dbl[9] = '{22, 24, 26, 42, 44, 46, 62, 64, 66};
    int exp_zero[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    int exp_spot[9] = '{0, 0, 0, 0, 255, 0, 0, 0, 0};
    int k_lap[9]   = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
    int k_id[9]    = '{0, 0, 0, 0, 1, 0, 0, 0, 0};

    conv3x3_stream_v2 #(
        .C_AXIS_TDATA_WIDTH(32), .PIXEL_NB(8), .KERNEL_NB(8),
        .IMG_WIDTH(5), .IMG_HEIGHT(5), .SHIFT(0)
    ) dut (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
        .s00_axis_tdata(s_tdata), .s00_axis_tstrb(s_tstrb),
        .s00_axis_tvalid(s_tvalid), .s00_axis_tready(s_tready),
        .s00_axis_tlast(s_tlast),
        .m00_axis_tdata(m_tdata), .m00_axis_tstrb(m_tstrb),
        .m00_axis_tvalid(m_tvalid), .m00_axis_tready(m_tready),
        .m00_axis_tlast(m_tlast),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Downstream ready changes at edge+1; the main sequence works at edge+2.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        m_tready = stall_mode ? ((cyc % 10 == 0) || (cyc % 10 == 3) || (cyc % 10 == 6))
                              : ready_req;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    logic        prev_stall = 1'b0;
    logic [31:0] prev_d = '0;
    logic        prev_l = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(m_tvalid), 32'd1);
                check("stall_data", m_tdata, prev_d);
                check("stall_last", 32'(m_tlast), 32'(prev_l));
            end
            if (m_tvalid && m_tready)
                q.push_back('{m_tdata, m_tlast});
            prev_stall = m_tvalid & ~m_tready;
            prev_d = m_tdata;
            prev_l = m_tlast;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic [7:0] pixv(input int mode, input int r, input int c);
        case (mode)
            0:       return 8'(10 * r + c);
            1:       return 8'd100;
            default: return (r == 2 && c == 2) ? 8'd200 : 8'd0;
        endcase
    endfunction

    task automatic send_pix(input logic [7:0] p, input logic last);
        bit ok;
        int n;
        n = 0;
        s_tdata = {24'hA5A5A5, p};
        s_tvalid = 1'b1;
        s_tlast = last;
        do begin
            ok = s_tready;
            tick(1);
            n++;
        end while (!ok && n < 1000);
        if (!ok)
            check("send_timeout", 32'd0, 32'd1);
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic send_frame(input int mode, input int first, input int stop,
                              input int err_idx, input bit no_tlast);
        for (int i = first; i < stop; i++)
            send_pix(pixv(mode, i / 5, i % 5), (i == err_idx) || (i == 24 && !no_tlast));
    endtask

    task automatic write_coef(input int a, input int d);
        cfg_we = 1'b1;
        cfg_addr = 4'(a);
        cfg_data = 8'(d);
        tick(1);
        cfg_we = 1'b0;
    endtask

    task automatic set_kernel(input int k[9]);
        for (int i = 0; i < 9; i++)
            write_coef(i, k[i]);
        tick(2);
    endtask

    task automatic check_frame(input string tag, input int e[9]);
        for (int i = 0; i < 400 && q.size() < 9; i++)
            tick(1);
        tick(4);
        check({tag, "_count"}, 32'(q.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < q.size()) begin
                check($sformatf("%s_data%0d", tag, i), q[i].d, 32'(e[i]));
                check($sformatf("%s_last%0d", tag, i), 32'(q[i].l), 32'(i == 8));
            end
        end
        q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tlast", 32'(m_tlast), 32'd0);
        check("rst_tdata", m_tdata, 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("tstrb", 32'(m_tstrb), 32'hF);
        rst_n = 1'b1;
        tick(1);
        check("rst_tready", 32'(s_tready), 32'd1);

        // Identity kernel, continuous flow, latency on the final beat.
        send_frame(0, 0, 25, -1, 1'b0);
        check("lat_prev_data", m_tdata, 32'd32);
        check("lat_prev_last", 32'(m_tlast), 32'd0);
        tick(1);
        check("lat_valid", 32'(m_tvalid), 32'd1);
        check("lat_data", m_tdata, 32'd33);
        check("lat_last", 32'(m_tlast), 32'd1);
        check_frame("ident", exp_id);

        set_kernel(k_lap);
        send_frame(1, 0, 25, -1, 1'b0);
        check_frame("lap_flat", exp_zero);
        send_frame(2, 0, 25, -1, 1'b0);
        check_frame("lap_spot", exp_spot);

        // Output backpressure with a 30% ready duty.
        set_kernel(k_id);
        stall_mode = 1'b1;
        send_frame(0, 0, 25, -1, 1'b0);
        check_frame("stall", exp_id);
        stall_mode = 1'b0;
        tick(2);

        // Mid-frame rewrite takes effect on the following frame only.
        send_frame(0, 0, 7, -1, 1'b0);
        write_coef(4, 2);
        send_frame(0, 7, 25, -1, 1'b0);
        check_frame("midwr_old", exp_id);
        send_frame(0, 0, 25, -1, 1'b0);
        check_frame("midwr_new", exp_dbl);

        // Early tlast at (2,3), then a clean frame.
        check("err_before", 32'(frame_err), 32'd0);
        send_frame(0, 0, 14, 13, 1'b0);
        tick(5);
        check("err_set", 32'(frame_err), 32'd1);
        q.delete();
        send_frame(0, 0, 25, -1, 1'b0);
        check_frame("after_err", exp_dbl);
        check("err_sticky", 32'(frame_err), 32'd1);

        // Asynchronous reset while an output is held by backpressure.
        send_frame(0, 0, 14, -1, 1'b0);
        ready_req = 1'b0;
        tick(4);
        check("hold_valid", 32'(m_tvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_tvalid", 32'(m_tvalid), 32'd0);
        check("arst_tdata", m_tdata, 32'd0);
        check("arst_tlast", 32'(m_tlast), 32'd0);
        check("arst_frame_err", 32'(frame_err), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        ready_req = 1'b1;
        tick(1);
        check("arst_tready", 32'(s_tready), 32'd1);
        q.delete();
        send_frame(0, 0, 25, -1, 1'b0);
        check_frame("post_rst", exp_id);

        // Missing tlast at the last position.
        send_frame(0, 0, 25, -1, 1'b1);
        check_frame("no_tlast", exp_id);
        check("no_tlast_err", 32'(frame_err), 32'd1);
        send_frame(0, 0, 25, -1, 1'b0);
        check_frame("wrap_ok", exp_id);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
